// File: rtl/cntry_car_detector.sv
// rtl/cntry_car_detector.sv - debounced country-road car request (X) front end for sig_control
// Define CAR_COUNT_EN to build the saturating CAR_COUNT grant counter; otherwise CAR_COUNT is tied to 0.
module cntry_car_detector #(
   parameter int DEB_CYCLES = 3,
   parameter int CNT_W      = 4
) (
   input  logic             CLOCK,
   input  logic             CLEAR,
   input  logic             SENSOR,
   input  logic [1:0]       CNTRY_SIG,
   output logic             CAR_ON_CNTRY_RD,
   output logic             SERVED,
   output logic [CNT_W-1:0] CAR_COUNT
);
   localparam int            DW       = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [1:0]    GREEN    = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_DEB, S_REQ, S_SERVE} state_t;

   state_t        state, state_n;
   logic [DW-1:0] deb_cnt, deb_n;
   logic          served_n;
   logic          green;

   // Encoding 2'd3 is invalid and simply fails this compare.
   assign green = (CNTRY_SIG == GREEN);

   always_comb begin
      state_n  = state;
      deb_n    = deb_cnt;
      served_n = 1'b0;
      case (state)
         S_IDLE: begin
            deb_n = '0;
            if (SENSOR) begin
               if (DEB_CYCLES == 1) begin
                  state_n = S_REQ;
               end else begin
                  state_n = S_DEB;
                  deb_n   = DW'(1);
               end
            end
         end
         S_DEB: begin
            if (!SENSOR) begin
               state_n = S_IDLE;
               deb_n   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n = S_REQ;
               deb_n   = '0;
            end else begin
               deb_n = deb_cnt + DW'(1);
            end
         end
         S_REQ: begin
            deb_n = '0;
            if (green) begin
               state_n  = S_SERVE;
               served_n = 1'b1;
            end
         end
         S_SERVE: begin
            // Losing GREEN without a grant re-queues a waiting car instead of pulsing SERVED.
            if (!green) begin
               deb_n   = '0;
               state_n = SENSOR ? S_REQ : S_IDLE;
            end else if (SENSOR) begin
               deb_n = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_n = S_IDLE;
               deb_n   = '0;
            end else begin
               deb_n = deb_cnt + DW'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            deb_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK or posedge CLEAR) begin
      if (CLEAR) begin
         state           <= S_IDLE;
         deb_cnt         <= '0;
         CAR_ON_CNTRY_RD <= 1'b0;
         SERVED          <= 1'b0;
      end else begin
         state           <= state_n;
         deb_cnt         <= deb_n;
         CAR_ON_CNTRY_RD <= (state_n == S_REQ) || (state_n == S_SERVE);
         SERVED          <= served_n;
      end
   end

`ifdef CAR_COUNT_EN
   logic [CNT_W-1:0] count;

   always_ff @(posedge CLOCK or posedge CLEAR) begin
      if (CLEAR) begin
         count <= '0;
      end else if (served_n && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

   assign CAR_COUNT = count;
`else
   assign CAR_COUNT = '0;
`endif

endmodule

// File: tb/tb_cntry_car_detector.sv
// tb/tb_cntry_car_detector.sv - directed scoreboard bench for cntry_car_detector (DEB_CYCLES=3, CNT_W=4)
// Expected CAR_COUNT follows the CAR_COUNT_EN build; X/SERVED expectations are build-independent.
module tb_cntry_car_detector;
   localparam logic [1:0] RED = 2'd0, YEL = 2'd1, GRN = 2'd2, BAD = 2'd3;

   logic       CLOCK = 1'b0;
   logic       CLEAR = 1'b1;
   logic       SENSOR = 1'b0;
   logic [1:0] CNTRY_SIG = 2'd0;
   logic       CAR_ON_CNTRY_RD;
   logic       SERVED;
   logic [3:0] CAR_COUNT;

   typedef struct packed {
      logic       x;
      logic       served;
      logic [3:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   grants = 0;

   cntry_car_detector #(.DEB_CYCLES(3), .CNT_W(4)) dut (
      .CLOCK(CLOCK),
      .CLEAR(CLEAR),
      .SENSOR(SENSOR),
      .CNTRY_SIG(CNTRY_SIG),
      .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
      .SERVED(SERVED),
      .CAR_COUNT(CAR_COUNT)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [3:0] cnt_exp(input int n);
`ifdef CAR_COUNT_EN
      return (n > 15) ? 4'd15 : 4'(n);
`else
      return (n > 15) ? 4'd0 : 4'd0;
`endif
   endfunction

   task automatic push_exp(input logic ex, input logic es, input int ec);
      exp_t e;
      e.x      = ex;
      e.served = es;
      e.cnt    = cnt_exp(ec);
      sbq.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      checks++;
      assert (sbq.size() > 0) else begin
         failures++;
         $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sbq.size());
      end
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         checks += 3;
         assert (CAR_ON_CNTRY_RD === e.x) else begin
            failures++;
            $error("FAIL %s x observed=%b expected=%b", tag, CAR_ON_CNTRY_RD, e.x);
         end
         assert (SERVED === e.served) else begin
            failures++;
            $error("FAIL %s served observed=%b expected=%b", tag, SERVED, e.served);
         end
         assert (CAR_COUNT === e.cnt) else begin
            failures++;
            $error("FAIL %s car_count observed=%0d expected=%0d", tag, CAR_COUNT, e.cnt);
         end
      end
   endtask

   // One clock: drive at negedge, record expectation, compare just after the rising edge.
   task automatic cyc(input string tag, input logic s, input logic [1:0] sig,
                      input logic ex, input logic es, input int ec);
      @(negedge CLOCK);
      SENSOR    = s;
      CNTRY_SIG = sig;
      push_exp(ex, es, ec);
      @(posedge CLOCK);
      #1;
      pop_check(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a car present: everything stays 0.
      CLEAR = 1'b1;
      for (int i = 0; i < 5; i++) cyc("reset", 1'b1, RED, 1'b0, 1'b0, 0);
      CLEAR = 1'b0;

      // Two-sample glitch is rejected and the filter returns to idle.
      cyc("glitch1", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("glitch2", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("glitch0", 1'b0, RED, 1'b0, 1'b0, 0);

      // Full debounce: X rises on the third sample, not earlier.
      cyc("deb1", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("deb2", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("deb3", 1'b1, RED, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) cyc("req_red", 1'b1, RED, 1'b1, 1'b0, 0);
      cyc("grant1", 1'b1, GRN, 1'b1, 1'b1, 1);
      cyc("serve1", 1'b1, GRN, 1'b1, 1'b0, 1);
      cyc("serve2", 1'b1, GRN, 1'b1, 1'b0, 1);
      cyc("clr1", 1'b0, GRN, 1'b1, 1'b0, 1);
      cyc("clr2", 1'b0, GRN, 1'b1, 1'b0, 1);
      cyc("clr3", 1'b0, GRN, 1'b0, 1'b0, 1);

      // Request raised while already GREEN is served on the following edge.
      cyc("gdeb1", 1'b1, GRN, 1'b0, 1'b0, 1);
      cyc("gdeb2", 1'b1, GRN, 1'b0, 1'b0, 1);
      cyc("gdeb3", 1'b1, GRN, 1'b1, 1'b0, 1);
      cyc("grant2", 1'b1, GRN, 1'b1, 1'b1, 2);

      // Timeout with car present re-queues; invalid signal code is not GREEN.
      cyc("timeout", 1'b1, YEL, 1'b1, 1'b0, 2);
      cyc("req_red2", 1'b1, RED, 1'b1, 1'b0, 2);
      cyc("req_bad", 1'b1, BAD, 1'b1, 1'b0, 2);
      cyc("grant3", 1'b1, GRN, 1'b1, 1'b1, 3);

      // Clear-count restarts on a SENSOR=1 sample.
      cyc("rst_c1", 1'b0, GRN, 1'b1, 1'b0, 3);
      cyc("rst_c2", 1'b0, GRN, 1'b1, 1'b0, 3);
      cyc("rst_car", 1'b1, GRN, 1'b1, 1'b0, 3);
      cyc("rst_c1b", 1'b0, GRN, 1'b1, 1'b0, 3);
      cyc("rst_c2b", 1'b0, GRN, 1'b1, 1'b0, 3);
      cyc("timeout0", 1'b0, YEL, 1'b0, 1'b0, 3);
      grants = 3;

      // Saturation: more grants than the 4-bit counter can hold.
      for (int g = 0; g < 14; g++) begin
         cyc("sat_d1", 1'b1, RED, 1'b0, 1'b0, grants);
         cyc("sat_d2", 1'b1, RED, 1'b0, 1'b0, grants);
         cyc("sat_d3", 1'b1, RED, 1'b1, 1'b0, grants);
         grants++;
         cyc("sat_grant", 1'b1, GRN, 1'b1, 1'b1, grants);
         cyc("sat_leave", 1'b0, YEL, 1'b0, 1'b0, grants);
      end

      // Asynchronous clear while requesting, then re-debounce after release.
      cyc("pre_d1", 1'b1, RED, 1'b0, 1'b0, grants);
      cyc("pre_d2", 1'b1, RED, 1'b0, 1'b0, grants);
      cyc("pre_d3", 1'b1, RED, 1'b1, 1'b0, grants);
      #2;
      CLEAR = 1'b1;
      #1;
      push_exp(1'b0, 1'b0, 0);
      pop_check("async_clr");
      @(posedge CLOCK);
      #1;
      push_exp(1'b0, 1'b0, 0);
      pop_check("clr_hold");
      CLEAR = 1'b0;
      cyc("post_d1", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("post_d2", 1'b1, RED, 1'b0, 1'b0, 0);
      cyc("post_d3", 1'b1, RED, 1'b1, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
